// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO UART transmitter.
// Address defaults, byte width and the UART state encoding.
package mmio_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_1000;
    localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_1004;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter.
// A push while full is honoured only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_en) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO store sink: TX byte register into a FIFO-fed UART, plus a HALT latch.
// Define MMIO_UART_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enab,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        halted,
    output logic [31:0] exit_code
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic              overflow_q;
    logic              halted_q;
    logic [31:0]       exit_q;
`ifdef MMIO_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              tx_hit;
    logic              halt_hit;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_dout;

    assign tx_hit   = write_enab && (data_addr == TX_ADDR);
    assign halt_hit = write_enab && (data_addr == HALT_ADDR);
    assign pop      = (state_q == IDLE) && !fifo_empty;
    assign push     = tx_hit && (!fifo_full || pop);

    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign overflow  = overflow_q;
    assign halted    = halted_q;
    assign exit_code = exit_q;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (write_data[BYTE_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow and first-store-wins halt capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            exit_q     <= '0;
        end else begin
            if (tx_hit && !push) begin
                overflow_q <= 1'b1;
            end
            if (halt_hit && !halted_q) begin
                halted_q <= 1'b1;
                exit_q   <= write_data;
            end
        end
    end

    // UART state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

`ifdef MMIO_UART_PARITY_EN
    // Parity of the byte in flight, computed once at load.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Next-state and line output; each non-idle state lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx      = 1'b1;
`ifdef MMIO_UART_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_dout;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
`ifdef MMIO_UART_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                tx = par_q;
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (baud_q == '0) begin
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Define MMIO_UART_PARITY_EN to exercise the parity build.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enab = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic        halted;
    logic [31:0] exit_code;

    int checks = 0;
    int errors = 0;

    logic rec_en = 1'b0;
    logic trace[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_enab (write_enab),
        .data_addr  (data_addr),
        .write_data (write_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .halted     (halted),
        .exit_code  (exit_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_en) trace.push_back(tx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(logic [31:0] addr, logic [31:0] data);
        write_enab = 1'b1;
        data_addr  = addr;
        write_data = data;
        tick();
        write_enab = 1'b0;
    endtask

    // Called one cycle after the start bit began; checks every cycle.
    task automatic check_frame(logic [7:0] b);
        logic bits [NB];
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[1+j] = b[j];
`ifdef MMIO_UART_PARITY_EN
        bits[9] = ^b;
`endif
        bits[NB-1] = 1'b1;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("frame_bit%0d", k), 32'(tx), 32'(bits[k]));
                chk("frame_busy", 32'(busy), 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        int prev;
        int pos;
        int n;
        bit saw_full;

        // Reset held 3 cycles, then quiet for 50 cycles.
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_exit", exit_code, 32'd0);
            tick();
        end

        // Single byte 0x41 with exact latency and frame timing.
        store(32'h1000, 32'h41);
        chk("lat_tx_e0", 32'(tx), 32'd1);
        chk("lat_busy_e0", 32'(busy), 32'd1);
        tick();
        check_frame(8'h41);
        chk("single_busy_end", 32'(busy), 32'd0);
        chk("single_tx_end", 32'(tx), 32'd1);

        // Ten back-to-back stores; ninth fills the FIFO, tenth drops.
        trace.delete();
        rec_en   = 1'b1;
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            store(32'h1000, 32'(i));
            if (fifo_full) saw_full = 1'b1;
        end
        chk("burst_full_seen", 32'(saw_full), 32'd1);
        chk("burst_overflow", 32'(overflow), 32'd1);
        n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        chk("burst_drain_timeout", 32'(n < 600), 32'd1);
        repeat (5) tick();
        rec_en = 1'b0;
        pos  = 0;
        prev = 0;
        for (int k = 0; k < 9; k++) begin
            int st;
            logic [7:0] rx;
            st = -1;
            for (int p = pos; p < trace.size(); p++) begin
                if (trace[p] == 1'b0) begin
                    st = p;
                    break;
                end
            end
            chk($sformatf("burst_frame%0d_found", k),
                32'(st >= 0 && st + CPB * NB <= trace.size()), 32'd1);
            if (st < 0 || st + CPB * NB > trace.size()) break;
            if (k > 0) chk("burst_gap", 32'(st - prev), 32'(CPB * NB + 1));
            for (int j = 0; j < 8; j++) rx[j] = trace[st + 6 + CPB * j];
            chk($sformatf("burst_byte%0d", k), 32'(rx), 32'(k));
`ifdef MMIO_UART_PARITY_EN
            chk("burst_parity", 32'(trace[st + 2 + CPB * 9]), 32'(^rx));
`endif
            chk("burst_stop", 32'(trace[st + 2 + CPB * (NB - 1)]), 32'd1);
            prev = st;
            pos  = st + CPB * NB;
        end
        n = 0;
        for (int p = pos; p < trace.size(); p++) if (trace[p] == 1'b0) n++;
        chk("burst_dropped_byte", 32'(n), 32'd0);

        // Non-decoded address and a deasserted strobe are ignored.
        store(32'h1008, 32'hFF);
        write_enab = 1'b0;
        data_addr  = 32'h1000;
        write_data = 32'h55;
        for (int i = 0; i < 20; i++) begin
            chk("ignore_tx", 32'(tx), 32'd1);
            chk("ignore_busy", 32'(busy), 32'd0);
            tick();
        end

        // First HALT store wins.
        store(32'h1004, 32'h19);
        chk("halt1_halted", 32'(halted), 32'd1);
        chk("halt1_exit", exit_code, 32'h19);
        chk("halt1_busy", 32'(busy), 32'd0);
        store(32'h1004, 32'h05);
        tick();
        chk("halt2_halted", 32'(halted), 32'd1);
        chk("halt2_exit", exit_code, 32'h19);

        // Reset 10 cycles into a frame with 3 bytes still queued.
        store(32'h1000, 32'hA1);
        store(32'h1000, 32'hA2);
        store(32'h1000, 32'hA3);
        store(32'h1000, 32'hA4);
        repeat (8) tick();
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        chk("midrst_exit", exit_code, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk("postrst_tx", 32'(tx), 32'd1);
            chk("postrst_busy", 32'(busy), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped store sink directly downstream of the single-cycle CPU `top`.
- Consumes the CPU's `write_enab`, `data_addr` and `write_data` store stream.
- Decodes two MMIO addresses:
  - a TX byte register, which feeds an 8N1 UART serializer through a small FIFO;
  - a HALT register, which latches a program exit code for simulation and board use.
- Write-only: the CPU never reads this block.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and ≥ 2.
- TX_ADDR, 32'h0000_1000, store address that enqueues `write_data[7:0]`.
- HALT_ADDR, 32'h0000_1004, store address that latches the exit code.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_enab  in  1  CPU store strobe, valid for one cycle per store.
- data_addr  in  32  CPU store address.
- write_data  in  32  CPU store data.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  out  1  FIFO count equals FIFO_DEPTH.
- overflow  out  1  sticky; set when a TX store is dropped.
- halted  out  1  sticky; set by the first HALT store.
- exit_code  out  32  `write_data` captured by the first HALT store.

Behaviour:
- Reset state (synchronous, active-high):
  - tx=1, busy=0, fifo_full=0, overflow=0, halted=0, exit_code=0;
  - FIFO emptied; FSM in IDLE.
  - Reset asserted mid-frame aborts the frame; tx=1 after that edge.
- Store decode:
  - A TX push requires `write_enab` AND `data_addr==TX_ADDR`. A HALT store requires `write_enab` AND `data_addr==HALT_ADDR`. All other stores are ignored.
  - A TX push is accepted if count<FIFO_DEPTH, OR if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow←1.
- Halt:
  - The first HALT store sets halted←1 and exit_code←write_data.
  - Later HALT stores are ignored.
  - Halt does not stop the UART.
- FIFO: in-order delivery; the count updates on every edge by +push −pop.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into a shift register, load the baud counter with CLKS_PER_BIT−1, go to START.
  - START: tx=0.
  - DATA: tx=shift[0], LSB first, 8 bits; a 3-bit index counts the bits.
  - STOP: tx=1. On expiry, return to IDLE; a queued byte is popped in that IDLE cycle.
  - Each non-IDLE state holds tx for exactly CLKS_PER_BIT cycles. The baud counter decrements and the state advances when it reaches 0.
- Frame timing and latency:
  - Frame length is 10·CLKS_PER_BIT cycles.
  - One IDLE cycle separates back-to-back frames.
  - A TX store registered at edge E0 makes tx fall after edge E1 when the FSM is idle.
- busy = (state≠IDLE) OR (count≠0).

Optional Feature:
- Macro: `MMIO_UART_PARITY_EN`.
- When defined:
  - a PARITY state is inserted between DATA and STOP;
  - it transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
  - frame length becomes 11·CLKS_PER_BIT.
- When undefined: no PARITY state or logic, and the frame is 8N1.

Decomposition:
- Package `mmio_pkg`:
  - TX_ADDR and HALT_ADDR default constants;
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - BYTE_W=8.
- Sub-module `sync_fifo`, parameterised width/depth:
  - push, pop, din, dout, full, empty;
  - same-cycle push+pop allowed when full.
- The top-level holds address decode, the halt registers and the UART FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset held 3 cycles, then released → tx=1, busy=0, overflow=0, halted=0, exit_code=0 for 50 cycles with no stores.
- Single store 0x41 to 0x1000 → tx low for 4 cycles starting after the second edge. Then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then stop=1. busy falls 40 cycles after tx falls.
- 10 back-to-back stores of 0x00..0x09 to 0x1000 → bytes 0x00..0x08 appear on tx in order, 0x09 is dropped, overflow=1, and fifo_full is observed high.
- Store 0xFF to 0x1008, and write_enab=0 with data_addr=0x1000 → tx stays 1 and busy stays 0.
- Store 0x19 to 0x1004, then 0x05 to 0x1004 → halted=1 and exit_code=0x0000_0019, holding through the second store.
- Reset asserted 10 cycles into a frame with 3 bytes queued → tx=1 and busy=0 after that edge, and no further frames after reset releases.
- With `MMIO_UART_PARITY_EN`: store 0x41 → the parity bit transmitted is 0, and the frame is 44 cycles.
